// File: rtl/dma_req_arbiter_pkg.sv
// Shared defaults and helpers for the DMA request arbiter.
//   - NUM_REQ_DEF / MAX_OUT_DEF / MAX_PER_REQ_DEF : default limits
//   - dma_descr_t : default descriptor payload (the cluster passes its own type)
//   - rr_wrap     : modular index advance used by the round-robin and FIFO pointers
package dma_req_arbiter_pkg;

    localparam int unsigned NUM_REQ_DEF     = 4;
    localparam int unsigned MAX_OUT_DEF     = 8;
    localparam int unsigned MAX_PER_REQ_DEF = 4;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LEN_W  = 32;

    // Default descriptor shape; matches the frontend's transfer descriptor layout.
    typedef struct packed {
        logic [ADDR_W-1:0] src_addr;
        logic [ADDR_W-1:0] dst_addr;
        logic [LEN_W-1:0]  num_bytes;
    } dma_descr_t;

    // (base + off) mod n, valid for base < n and off <= n.
    function automatic int unsigned rr_wrap(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned n);
        int unsigned sum;
        sum = base + off;
        return (sum >= n) ? (sum - n) : sum;
    endfunction

endpackage

// File: rtl/dma_req_arbiter_fifo.sv
// In-order index FIFO recording which requester owns each issued transfer.
// Head is read straight from storage (no fall-through).
//   clk_i, rst_ni : clock, async active-low reset
//   push_i/data_i : enqueue an index (accepted when not full, or full with a pop)
//   pop_i/data_o  : dequeue head (ignored when empty)
//   empty_o       : FIFO holds no entries
//   usage_o       : current occupancy
module dma_req_arbiter_fifo
    import dma_req_arbiter_pkg::*;
#(
    parameter int unsigned DataW  = 2,
    parameter int unsigned Depth  = 8,
    parameter int unsigned UsageW = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DataW-1:0]  data_i,
    input  logic              pop_i,
    output logic [DataW-1:0]  data_o,
    output logic              empty_o,
    output logic [UsageW-1:0] usage_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [DataW-1:0]  r_mem [Depth];
    logic [PtrW-1:0]   r_wr_ptr;
    logic [PtrW-1:0]   r_rd_ptr;
    logic [UsageW-1:0] r_usage;

    logic              w_full;
    logic              w_empty;
    logic              w_do_push;
    logic              w_do_pop;
    logic [PtrW-1:0]   w_wr_ptr_nxt;
    logic [PtrW-1:0]   w_rd_ptr_nxt;

    assign w_full  = (r_usage == UsageW'(Depth));
    assign w_empty = (r_usage == '0);

    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
    assign w_do_pop  = pop_i & ~w_empty;
    assign w_do_push = push_i & (~w_full | w_do_pop);

    assign w_wr_ptr_nxt = PtrW'(rr_wrap(32'(r_wr_ptr), 1, Depth));
    assign w_rd_ptr_nxt = PtrW'(rr_wrap(32'(r_rd_ptr), 1, Depth));

    // Storage: data only, no reset needed.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usage  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            if (w_do_push && !w_do_pop) begin
                r_usage <= r_usage + UsageW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_usage <= r_usage - UsageW'(1);
            end
        end
    end

    assign data_o  = r_mem[r_rd_ptr];
    assign empty_o = w_empty;
    assign usage_o = r_usage;

endmodule

// File: rtl/dma_req_arbiter.sv
// Round-robin arbiter sharing the DMA frontend's single descriptor port among
// NumReq requesters, with per-requester and global in-flight limits and
// in-order routing of completion pulses back to the owning requester.
//   clk_i, rst_ni        : clock, async active-low reset
//   req_valid_i/ready_o  : per-requester descriptor handshake (ready is comb, one-hot)
//   req_i                : per-requester descriptor
//   rsp_valid_o          : per-requester completion pulse (comb from dma_rsp_valid_i)
//   dma_req_valid_o/_o   : registered descriptor toward the frontend
//   dma_req_ready_i      : frontend accepts the descriptor
//   dma_rsp_valid_i      : frontend completion, one per transfer in issue order
//   busy_o               : output register full or transfers outstanding
//   rsp_err_o            : completion received with nothing outstanding
module dma_req_arbiter
    import dma_req_arbiter_pkg::*;
#(
    parameter int unsigned NumReq         = NUM_REQ_DEF,
    parameter int unsigned MaxOutstanding = MAX_OUT_DEF,
    parameter int unsigned MaxPerReq      = MAX_PER_REQ_DEF,
    parameter type         dma_transf_descr_t = dma_descr_t
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NumReq-1:0]              req_valid_i,
    output logic [NumReq-1:0]              req_ready_o,
    input  dma_transf_descr_t [NumReq-1:0] req_i,
    output logic [NumReq-1:0]              rsp_valid_o,
    output logic                           dma_req_valid_o,
    input  logic                           dma_req_ready_i,
    output dma_transf_descr_t              dma_req_o,
    input  logic                           dma_rsp_valid_i,
    output logic                           busy_o,
    output logic                           rsp_err_o
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned CntW = $clog2(MaxPerReq + 1);
    localparam int unsigned TotW = $clog2(MaxOutstanding + 1);

    // Output stage and arbitration state.
    logic              r_out_valid;
    logic [IdxW-1:0]   r_out_idx;
    dma_transf_descr_t r_out_descr;
    logic [IdxW-1:0]   r_last_ptr;
    logic [CntW-1:0]   r_cnt [NumReq];

    logic              w_issue;
    logic              w_out_free;
    logic              w_room;
    logic              w_any_elig;
    logic              w_grant;
    logic              w_pop;
    logic              w_fifo_empty;
    logic [IdxW-1:0]   w_grant_idx;
    logic [IdxW-1:0]   w_cand;
    logic [IdxW-1:0]   w_fifo_head;
    logic [TotW-1:0]   w_fifo_usage;
    logic [TotW-1:0]   w_total;
    logic [NumReq-1:0] w_eligible;

    assign w_issue    = r_out_valid & dma_req_ready_i;
    assign w_out_free = ~r_out_valid | dma_req_ready_i;
    assign w_total    = w_fifo_usage + TotW'(r_out_valid);
    assign w_room     = (w_total < TotW'(MaxOutstanding));

    // Eligibility from pre-update counters; a same-cycle completion gives no credit.
    always_comb begin
        w_eligible = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            w_eligible[i] = req_valid_i[i] & (r_cnt[i] < CntW'(MaxPerReq)) & w_room;
        end
    end

    // Round-robin: first eligible index after r_last_ptr, wrapping.
    always_comb begin
        w_any_elig  = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int unsigned k = 1; k <= NumReq; k++) begin
            w_cand = IdxW'(rr_wrap(32'(r_last_ptr), k, NumReq));
            if (!w_any_elig && w_eligible[w_cand]) begin
                w_any_elig  = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    // Combinational handshake outputs are held quiet while reset is asserted.
    assign w_grant = rst_ni & w_out_free & w_any_elig;
    assign w_pop   = rst_ni & dma_rsp_valid_i & ~w_fifo_empty;

    always_comb begin
        req_ready_o = '0;
        if (w_grant) begin
            req_ready_o[w_grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        if (w_pop) begin
            rsp_valid_o[w_fifo_head] = 1'b1;
        end
    end

    assign rsp_err_o = rst_ni & dma_rsp_valid_i & w_fifo_empty;

    // Output register; held while valid and not accepted, refilled on accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_descr <= '0;
            r_last_ptr  <= IdxW'(NumReq - 1);
        end else if (w_grant) begin
            r_out_valid <= 1'b1;
            r_out_idx   <= w_grant_idx;
            r_out_descr <= req_i[w_grant_idx];
            r_last_ptr  <= w_grant_idx;
        end else if (w_issue) begin
            r_out_valid <= 1'b0;
        end
    end

    // Per-requester in-flight counters: +1 on grant, -1 on routed completion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NumReq; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NumReq; i++) begin
                if (req_ready_o[i] && !rsp_valid_o[i]) begin
                    r_cnt[i] <= r_cnt[i] + CntW'(1);
                end else if (!req_ready_o[i] && rsp_valid_o[i]) begin
                    r_cnt[i] <= r_cnt[i] - CntW'(1);
                end
            end
        end
    end

    dma_req_arbiter_fifo #(
        .DataW  (IdxW),
        .Depth  (MaxOutstanding),
        .UsageW (TotW)
    ) u_idx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_issue),
        .data_i  (r_out_idx),
        .pop_i   (w_pop),
        .data_o  (w_fifo_head),
        .empty_o (w_fifo_empty),
        .usage_o (w_fifo_usage)
    );

    assign dma_req_valid_o = r_out_valid;
    assign dma_req_o       = r_out_descr;
    assign busy_o          = r_out_valid | ~w_fifo_empty;

endmodule

// File: tb/tb_dma_req_arbiter.sv
// Randomized and directed bench for dma_req_arbiter against a queue-based model.
module tb_dma_req_arbiter;
    import dma_req_arbiter_pkg::*;

    localparam int NR   = 4;
    localparam int MAXO = 8;
    localparam int MAXP = 4;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NR-1:0]           req_valid;
    logic [NR-1:0]           req_ready;
    dma_descr_t [NR-1:0]     req_descr;
    logic [NR-1:0]           rsp_valid;
    logic                    dma_valid;
    logic                    dma_ready;
    dma_descr_t              dma_descr;
    logic                    dma_rsp;
    logic                    busy;
    logic                    rsp_err;

    always #5 clk = ~clk;

    dma_req_arbiter dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_i           (req_descr),
        .rsp_valid_o     (rsp_valid),
        .dma_req_valid_o (dma_valid),
        .dma_req_ready_i (dma_ready),
        .dma_req_o       (dma_descr),
        .dma_rsp_valid_i (dma_rsp),
        .busy_o          (busy),
        .rsp_err_o       (rsp_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: output slot plus queue of in-flight owners.
    bit         m_out_valid;
    int         m_out_idx;
    dma_descr_t m_out_descr;
    int         m_last;
    int         m_cnt [NR];
    int         m_q [$];
    int         obs_grants [$];
    int         obs_rsps [$];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int oh_idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_out_valid = 1'b0;
        m_out_idx   = 0;
        m_out_descr = '0;
        m_last      = NR - 1;
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        m_q.delete();
    endtask

    // One clock: drive at negedge, compare #1 later, then advance the model.
    task automatic step(input logic [NR-1:0] rv, input logic rdy, input logic rsp);
        int            g;
        int            total;
        bit            pop;
        bit            issue;
        logic [NR-1:0] exp_ready;
        logic [NR-1:0] exp_rsp;
        @(negedge clk);
        req_valid = rv;
        dma_ready = rdy;
        dma_rsp   = rsp;
        for (int i = 0; i < NR; i++) req_descr[i] = {$urandom, $urandom, $urandom};
        #1;
        total = m_q.size() + int'(m_out_valid);
        g = -1;
        if (!m_out_valid || rdy) begin
            for (int k = 1; k <= NR; k++) begin
                int c;
                c = (m_last + k) % NR;
                if (g < 0 && rv[c] && m_cnt[c] < MAXP && total < MAXO) g = c;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        pop   = rsp && (m_q.size() > 0);
        issue = m_out_valid && rdy;
        exp_rsp = '0;
        if (pop) exp_rsp[m_q[0]] = 1'b1;

        check_eq("req_ready", 128'(req_ready), 128'(exp_ready));
        check_eq("rsp_valid", 128'(rsp_valid), 128'(exp_rsp));
        check_eq("rsp_err",   128'(rsp_err),   128'(rsp && (m_q.size() == 0)));
        check_eq("dma_valid", 128'(dma_valid), 128'(m_out_valid));
        if (m_out_valid) check_eq("dma_descr", 128'(dma_descr), 128'(m_out_descr));
        check_eq("busy",      128'(busy),      128'(m_out_valid || (m_q.size() > 0)));

        if (req_ready != '0) obs_grants.push_back(oh_idx(req_ready));
        if (rsp_valid != '0) obs_rsps.push_back(oh_idx(rsp_valid));

        if (pop) begin
            int h;
            h = m_q.pop_front();
            m_cnt[h]--;
        end
        if (issue) m_q.push_back(m_out_idx);
        if (g >= 0) begin
            m_out_valid = 1'b1;
            m_out_idx   = g;
            m_out_descr = req_descr[g];
            m_last      = g;
            m_cnt[g]++;
        end else if (issue) begin
            m_out_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) step('0, 1'b1, 1'b1);
    endtask

    initial begin
        int rot_exp [6] = '{0, 1, 2, 3, 0, 1};
        int glb_exp [8] = '{0, 1, 0, 1, 0, 1, 0, 1};

        rst_n     = 1'b0;
        req_valid = '0;
        dma_ready = 1'b0;
        dma_rsp   = 1'b0;
        req_descr = '0;
        model_reset();
        #1;
        check_eq("rst_dma_valid", 128'(dma_valid), 128'(0));
        check_eq("rst_dma_descr", 128'(dma_descr), 128'(0));
        check_eq("rst_req_ready", 128'(req_ready), 128'(0));
        check_eq("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check_eq("rst_busy",      128'(busy),      128'(0));
        check_eq("rst_err",       128'(rsp_err),   128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Fair rotation with completions every cycle.
        obs_grants.delete();
        for (int i = 0; i < 8; i++) step(4'hF, 1'b1, 1'b1);
        check_eq("rot_count", 128'(obs_grants.size()), 128'(8));
        for (int i = 0; i < 6; i++) begin
            if (i < obs_grants.size()) check_eq("rot_order", 128'(obs_grants[i]), 128'(rot_exp[i]));
        end
        drain();

        // Per-requester limit on requester 2.
        obs_grants.delete();
        obs_rsps.delete();
        for (int i = 0; i < 8; i++) step(4'b0100, 1'b1, 1'b0);
        check_eq("perreq_grants", 128'(obs_grants.size()), 128'(4));
        step(4'b0100, 1'b1, 1'b1);
        check_eq("perreq_rsp2", 128'(rsp_valid), 128'(4'b0100));
        step(4'b0100, 1'b1, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        check_eq("perreq_fifth", 128'(obs_grants.size()), 128'(5));
        drain();

        // Global limit with requesters 0 and 1.
        obs_grants.delete();
        obs_rsps.delete();
        for (int i = 0; i < 12; i++) step(4'b0011, 1'b1, 1'b0);
        check_eq("global_grants", 128'(obs_grants.size()), 128'(8));
        check_eq("global_busy",   128'(busy), 128'(1));
        for (int i = 0; i < 8; i++) step('0, 1'b1, 1'b1);
        check_eq("global_rsp_count", 128'(obs_rsps.size()), 128'(8));
        for (int i = 0; i < 8; i++) begin
            if (i < obs_rsps.size()) check_eq("global_rsp_order", 128'(obs_rsps[i]), 128'(glb_exp[i]));
        end
        drain();

        // Backpressure: descriptor holds, single grant until released.
        obs_grants.delete();
        for (int i = 0; i < 6; i++) step(4'hF, 1'b0, 1'b0);
        check_eq("bp_grants", 128'(obs_grants.size()), 128'(1));
        step(4'hF, 1'b1, 1'b0);
        check_eq("bp_refill", 128'(obs_grants.size()), 128'(2));
        drain();

        // Completion with nothing outstanding.
        step('0, 1'b1, 1'b1);
        check_eq("err_pulse", 128'(rsp_err),   128'(1));
        check_eq("err_rsp0",  128'(rsp_valid), 128'(0));
        step('0, 1'b1, 1'b0);

        // Async reset mid-burst with three outstanding.
        for (int i = 0; i < 3; i++) step(4'hF, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        dma_rsp = 1'b1;
        rst_n   = 1'b0;
        #1;
        check_eq("arst_dma_valid", 128'(dma_valid), 128'(0));
        check_eq("arst_req_ready", 128'(req_ready), 128'(0));
        check_eq("arst_rsp_valid", 128'(rsp_valid), 128'(0));
        check_eq("arst_busy",      128'(busy),      128'(0));
        check_eq("arst_err",       128'(rsp_err),   128'(0));
        model_reset();
        req_valid = '0;
        dma_rsp   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        obs_grants.delete();
        step(4'hF, 1'b1, 1'b0);
        check_eq("arst_first_grant", 128'(oh_idx(req_ready)), 128'(0));

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            step(NR'($urandom), ($urandom % 4) != 0, ($urandom % 3) == 0);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
